// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int   SamplesPerBitDefault = 16;
    localparam logic StartBit             = 1'b0;
    localparam logic StopBit              = 1'b1;
    localparam int   DataBits             = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, oversampled by sample_trigger, held valid/ack output
module uart_rx
    import uart_pkg::*;
#(
    parameter int SamplesPerBit = SamplesPerBitDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_trigger,
    input  logic                serial_data,
    input  logic                data_ack,
    output logic [DataBits-1:0] data,
    output logic                valid,
    output logic                overrun,
    output logic                framing_error,
    output logic                busy
);

    localparam int TickW = $clog2(SamplesPerBit + 1);
    localparam int BitW  = $clog2(DataBits);
    localparam logic [TickW-1:0] HalfTick = TickW'(SamplesPerBit / 2);
    localparam logic [TickW-1:0] FullTick = TickW'(SamplesPerBit);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DataBits - 1);

    logic rx_s;

    sync_2ff #(.ResetVal(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (serial_data),
        .q   (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d, tick_inc;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DataBits-1:0]  shift_q, shift_d;
    logic [DataBits-1:0]  data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 fe_q, fe_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            fe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            fe_q      <= fe_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        fe_d      = 1'b0;
        tick_inc  = tick_q + 1'b1;

        // Ack is applied first so a byte completing in the same cycle overrides it.
        if (data_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (sample_trigger) begin
            case (state_q)
                IDLE: begin
                    if (rx_s == StartBit) begin
                        state_d = START;
                        tick_d  = TickW'(1);
                    end
                end
                START: begin
                    if (tick_inc == HalfTick) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = (rx_s == StartBit) ? DATA : IDLE;
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                DATA: begin
                    if (tick_inc == FullTick) begin
                        tick_d         = '0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == LastBit) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                STOP: begin
                    if (tick_inc == FullTick) begin
                        tick_d = '0;
                        if (rx_s == StopBit) begin
                            data_d    = shift_q;
                            valid_d   = 1'b1;
                            overrun_d = valid_q && !data_ack;
                            state_d   = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s == StopBit) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign overrun       = overrun_q;
    assign framing_error = fe_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a byte-level model
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_trigger = 1'b0;
    logic       serial_data = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       framing_error;
    logic       busy;

    int total = 0;
    int bad = 0;
    int trig_period = 4;
    int trig_jit = 0;
    int fe_pulses = 0;

    // Byte-level model of what the consumer should see.
    logic [7:0] m_data = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_overrun = 1'b0;

    uart_rx #(.SamplesPerBit(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_trigger (sample_trigger),
        .serial_data    (serial_data),
        .data_ack       (data_ack),
        .data           (data),
        .valid          (valid),
        .overrun        (overrun),
        .framing_error  (framing_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // One trigger per window of trig_period clks, displaced by up to trig_jit clks (non-accumulating).
    initial begin : trig_gen
        int d;
        forever begin
            d = $urandom_range(0, trig_jit);
            for (int k = 0; k < trig_period; k++) begin
                @(negedge clk);
                sample_trigger = (k == d);
            end
        end
    end

    always @(negedge clk) if (framing_error === 1'b1) fe_pulses++;

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (good) begin
            m_overrun = m_valid;
            m_valid   = 1'b1;
            m_data    = b;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_val, input int bit_clks, input int stop_clks);
        logic [9:0] fr;
        fr = {stop_val, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_data = fr[i];
            repeat ((i == 9) ? stop_clks : bit_clks) @(negedge clk);
        end
        model_frame(b, stop_val);
    endtask

    task automatic do_ack();
        @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (valid !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= budget) begin
            bad++;
            $display("FAIL wait_valid: got timeout after %0d clks want valid", cyc);
        end
    endtask

    task automatic check_outputs(input string tag);
        total++;
        if (data !== m_data) begin
            bad++;
            $display("FAIL %s data: got %02h want %02h", tag, data, m_data);
        end
        total++;
        if (valid !== m_valid) begin
            bad++;
            $display("FAIL %s valid: got %b want %b", tag, valid, m_valid);
        end
        total++;
        if (overrun !== m_overrun) begin
            bad++;
            $display("FAIL %s overrun: got %b want %b", tag, overrun, m_overrun);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        total++;
        if (framing_error !== 1'b0) begin
            bad++;
            $display("FAIL reset framing_error: got %b want 0", framing_error);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] pats [5] = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
        int cyc;
        foreach (pats[i]) begin
            fork
                send_frame(pats[i], 1'b1, 64, 64);
                wait_valid(800, cyc);
            join
            // Stop-bit midpoint is 9.5 bits = 608 clks after the falling start edge.
            total++;
            if (cyc < 600 || cyc > 616) begin
                bad++;
                $display("FAIL basic latency: got %0d clks want 600..616", cyc);
            end
            check_outputs("basic");
            do_ack();
            check_outputs("basic_ack");
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h3C, 1'b1, 64, 64);
        check_outputs("b2b_first");
        send_frame(8'hC3, 1'b1, 64, 64);
        check_outputs("b2b_second");
        do_ack();
        check_outputs("b2b_ack");
        repeat (16) @(negedge clk);
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_pulses;
        serial_data = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch busy_low: got %b want 1", busy);
        end
        serial_data = 1'b1;
        repeat (60) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch busy_idle: got %b want 0", busy);
        end
        total++;
        if (fe_pulses !== fe0) begin
            bad++;
            $display("FAIL glitch framing_error: got %0d pulses want 0", fe_pulses - fe0);
        end
        check_outputs("glitch");
    endtask

    task automatic test_framing();
        int fe0;
        fe0 = fe_pulses;
        send_frame(8'h55, 1'b0, 64, 120);
        serial_data = 1'b1;
        repeat (64) @(negedge clk);
        total++;
        if (fe_pulses - fe0 !== 1) begin
            bad++;
            $display("FAIL framing pulse_clks: got %0d want 1", fe_pulses - fe0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL framing busy: got %b want 0", busy);
        end
        check_outputs("framing");
        send_frame(8'h12, 1'b1, 64, 64);
        check_outputs("framing_next");
        do_ack();
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_frame(8'h77, 1'b1, 64, 64);
        check_outputs("pre_reset");
        fork
            send_frame(8'hF0, 1'b1, 64, 64);
            begin
                repeat (64 * 5 + 32) @(negedge clk);
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_mid busy_before: got %b want 1", busy);
                end
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                m_data    = 8'h00;
                m_valid   = 1'b0;
                m_overrun = 1'b0;
                check_outputs("reset_mid");
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid busy: got %b want 0", busy);
                end
            end
        join
        // The aborted frame must not be delivered when the rest of it arrives.
        m_valid = 1'b0;
        m_data  = 8'h00;
        check_outputs("reset_mid_tail");
        send_frame(8'h0F, 1'b1, 64, 64);
        check_outputs("reset_next");
        do_ack();
        repeat (16) @(negedge clk);
    endtask

    task automatic test_jitter();
        int fe0;
        int cyc;
        int bitc;
        logic [7:0] b;
        fe0 = fe_pulses;
        trig_period = 2;
        trig_jit = 1;
        repeat (8) @(negedge clk);
        for (int n = 0; n < 200; n++) begin
            b = 8'($urandom);
            bitc = ($urandom_range(0, 1) == 1) ? 33 : 31;
            fork
                send_frame(b, 1'b1, bitc, bitc);
                begin
                    wait_valid(bitc * 11, cyc);
                    total++;
                    if (data !== b) begin
                        bad++;
                        $display("FAIL jitter data #%0d: got %02h want %02h", n, data, b);
                    end
                    total++;
                    if (overrun !== 1'b0) begin
                        bad++;
                        $display("FAIL jitter overrun #%0d: got %b want 0", n, overrun);
                    end
                    do_ack();
                end
            join
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        total++;
        if (fe_pulses !== fe0) begin
            bad++;
            $display("FAIL jitter framing_error: got %0d pulses want 0", fe_pulses - fe0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_jitter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
